// File: rtl/sm3_seed_set_packer.sv
// Seed collector for the two-block SM3 tree hasher: packs NUM_SEEDS seeds into a
// padded 1024-bit message, runs the Hstart/en_end handshake and hands the digest on.
module sm3_seed_set_packer #(
  parameter int SEED_W    = 128,
  parameter int NUM_SEEDS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [SEED_W-1:0] seed_in,
  input  logic              seed_valid,
  output logic              seed_ready,
  output logic [1023:0]     h3InSeedSet,
  output logic              Hstart,
  input  logic              en_end,
  input  logic [255:0]      hashValue,
  output logic [255:0]      digest_out,
  output logic              digest_valid,
  input  logic              digest_ready
);

  localparam int L     = NUM_SEEDS * SEED_W;
  localparam int CNT_W = (NUM_SEEDS > 1) ? $clog2(NUM_SEEDS) : 1;

  // Everything from the '1' marker down to bit 0 is rewritten in PAD.
  localparam logic [1023:0] TAIL_MASK = {1024{1'b1}} >> L;
  localparam logic [1023:0] PAD_BITS  = (1024'(1) << (1023 - L)) | 1024'(L);

  generate
    if (L < 448 || L > 959) begin : g_bad_len
      $error("sm3_seed_set_packer: NUM_SEEDS*SEED_W must lie in 448..959");
    end
  endgenerate

  typedef enum logic [2:0] {COLLECT, PAD, HASH, DRAIN, OUT} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1023:0]      msg_q, msg_d;
  logic               hstart_q, hstart_d;
  logic [255:0]       digest_q, digest_d;
  logic               dv_q, dv_d;
  logic               ready_q;

  always_comb begin
    // NOTE: every variable gets its hold value first so no path can infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    msg_d    = msg_q;
    hstart_d = hstart_q;
    digest_d = digest_q;
    dv_d     = dv_q;
    unique case (state_q)
      COLLECT: begin
        if (seed_valid && ready_q) begin
          msg_d[1023 - int'(cnt_q) * SEED_W -: SEED_W] = seed_in;
          if (cnt_q == CNT_W'(NUM_SEEDS - 1)) state_d = PAD;
          else                                cnt_d   = cnt_q + 1'b1;
        end
      end
      PAD: begin
        msg_d    = (msg_q & ~TAIL_MASK) | PAD_BITS;
        hstart_d = 1'b1;
        state_d  = HASH;
      end
      HASH: begin
        if (en_end) begin
          digest_d = hashValue;
          hstart_d = 1'b0;
          state_d  = DRAIN;
        end
      end
      DRAIN: begin
        // Hstart must not be re-raised until the hasher has dropped en_end.
        if (!en_end) begin
          dv_d    = 1'b1;
          state_d = OUT;
        end
      end
      OUT: begin
        if (digest_ready) begin
          dv_d    = 1'b0;
          cnt_d   = '0;
          msg_d   = '0;
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so all flops sample together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= COLLECT;
      cnt_q    <= '0;
      // NOTE: the message register is reset too, so a partial message never leaks out.
      msg_q    <= '0;
      hstart_q <= 1'b0;
      digest_q <= '0;
      dv_q     <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      msg_q    <= msg_d;
      hstart_q <= hstart_d;
      digest_q <= digest_d;
      dv_q     <= dv_d;
      ready_q  <= (state_d == COLLECT);
    end
  end

  assign seed_ready   = ready_q;
  assign h3InSeedSet  = msg_q;
  assign Hstart       = hstart_q;
  assign digest_out   = digest_q;
  assign digest_valid = dv_q;

endmodule

// File: tb/tb_sm3_seed_set_packer.sv
// Scoreboard bench for sm3_seed_set_packer: stub hasher, message layout checks,
// handshake timing, backpressure and mid-hash reset.
module tb_sm3_seed_set_packer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // 4-seed instance with stub hasher
  logic [127:0]  seed_in;
  logic          seed_valid, seed_ready;
  logic [1023:0] h3;
  logic          Hstart, en_end;
  logic [255:0]  hash_value, digest_out;
  logic          digest_valid, digest_ready;

  // 7-seed instance, layout only
  logic [127:0]  seed7_in;
  logic          seed7_valid, seed7_ready;
  logic [1023:0] h3_7;
  logic          hstart7;
  logic [255:0]  digest7_out;
  logic          digest7_valid;

  sm3_seed_set_packer #(.SEED_W(128), .NUM_SEEDS(4)) dut (
    .clk(clk), .reset(reset), .seed_in(seed_in), .seed_valid(seed_valid),
    .seed_ready(seed_ready), .h3InSeedSet(h3), .Hstart(Hstart), .en_end(en_end),
    .hashValue(hash_value), .digest_out(digest_out), .digest_valid(digest_valid),
    .digest_ready(digest_ready));

  sm3_seed_set_packer #(.SEED_W(128), .NUM_SEEDS(7)) dut7 (
    .clk(clk), .reset(reset), .seed_in(seed7_in), .seed_valid(seed7_valid),
    .seed_ready(seed7_ready), .h3InSeedSet(h3_7), .Hstart(hstart7), .en_end(1'b0),
    .hashValue(256'd0), .digest_out(digest7_out), .digest_valid(digest7_valid),
    .digest_ready(1'b0));

  int n_vec = 0;
  int n_err = 0;
  logic [255:0] sb_q [$];
  int accepted = 0;
  int pops = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic check_msg(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
    for (int c = 0; c < 4; c++)
      check($sformatf("%s[%0d]", tag, c), got[1023 - c*256 -: 256], exp[1023 - c*256 -: 256]);
  endtask

  function automatic logic [1023:0] build_msg(input logic [127:0] s [7], input int n);
    logic [1023:0] m;
    int len;
    len = n * 128;
    m = '0;
    for (int k = 0; k < n; k++) m[1023 - k*128 -: 128] = s[k];
    m[1023 - len] = 1'b1;
    m[63:0] = 64'(len);
    return m;
  endfunction

  // Order-sensitive fold standing in for SM3.
  function automatic logic [255:0] stub_hash(input logic [1023:0] m);
    return m[1023:768] ^ {m[766:512], m[767]} ^ m[511:256] ^ {m[254:0], m[255]}
           ^ {8{32'hDEADBEEF}};
  endfunction

  // Stub hasher: en_end 10 cycles after Hstart, cleared 3 cycles after Hstart drops.
  int stub_cnt;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_end     <= 1'b0;
      hash_value <= '0;
      stub_cnt   <= 0;
    end else if (Hstart && !en_end) begin
      if (stub_cnt == 9) begin
        en_end     <= 1'b1;
        hash_value <= stub_hash(h3);
        stub_cnt   <= 0;
      end else stub_cnt <= stub_cnt + 1;
    end else if (!Hstart && en_end) begin
      if (stub_cnt == 2) begin
        en_end   <= 1'b0;
        stub_cnt <= 0;
      end else stub_cnt <= stub_cnt + 1;
    end
  end

  always @(posedge clk) begin
    if (reset && seed_valid && seed_ready) accepted <= accepted + 1;
    if (reset && digest_valid && digest_ready) begin
      if (sb_q.size() == 0) check("sb_underflow", 256'(1), 256'(0));
      else                  check("digest", digest_out, sb_q.pop_front());
      pops <= pops + 1;
    end
  end

  logic hs_en_prev = 1'b0;
  logic dv_prev = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      if (hs_en_prev) check("hstart_drop", 256'(Hstart), 256'(0));
      if (digest_valid && !dv_prev) check("dv_after_en_end_low", 256'(en_end), 256'(0));
      if (Hstart || digest_valid) check("ready_outside_collect", 256'(seed_ready), 256'(0));
    end
    hs_en_prev <= Hstart && en_end;
    dv_prev    <= digest_valid;
  end

  // Entered just after a negedge; returns just after the negedge following acceptance.
  task automatic send_seed(input logic [127:0] s, input int max_gap);
    bit hs;
    int gap;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    seed_valid = 1'b0;
    repeat (gap) @(negedge clk);
    seed_in = s;
    seed_valid = 1'b1;
    hs = 1'b0;
    for (int t = 0; t < 100 && !hs; t++) begin
      hs = seed_ready;
      @(negedge clk);
    end
    if (!hs) check("seed_timeout", 256'(0), 256'(1));
  endtask

  task automatic send_msg(input logic [127:0] s [7], input int max_gap, input bit hold_valid);
    sb_q.push_back(stub_hash(build_msg(s, 4)));
    for (int k = 0; k < 4; k++) send_seed(s[k], max_gap);
    if (hold_valid) seed_in = {4{32'hBAD0_5EED}};
    else            seed_valid = 1'b0;
  endtask

  task automatic wait_pops(input int target);
    for (int t = 0; t < 500 && pops < target; t++) @(negedge clk);
    if (pops < target) check("digest_timeout", 256'(pops), 256'(target));
  endtask

  task automatic rand_seeds(output logic [127:0] s [7]);
    for (int k = 0; k < 7; k++) s[k] = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] s [7];
    logic [127:0] s7 [7];
    int acc0;
    bit hs;

    reset = 1'b0; seed_valid = 1'b0; seed_in = '0; digest_ready = 1'b0;
    seed7_valid = 1'b0; seed7_in = '0;
    repeat (2) @(negedge clk);
    check("rst_hstart", 256'(Hstart), 256'(0));
    check("rst_dv", 256'(digest_valid), 256'(0));
    check("rst_digest", digest_out, 256'(0));
    check_msg("rst_msg", h3, '0);
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 256'(seed_ready), 256'(1));

    // Back-to-back seeds 1..4, latency and layout
    s = '{128'd1, 128'd2, 128'd3, 128'd4, 128'd0, 128'd0, 128'd0};
    digest_ready = 1'b1;
    send_msg(s, 0, 1'b0);
    check("hstart_in_pad", 256'(Hstart), 256'(0));
    @(negedge clk);
    check("hstart_latency", 256'(Hstart), 256'(1));
    check_msg("msg4", h3, build_msg(s, 4));
    check("len4", 256'(h3[63:0]), 256'(64'h200));
    check("padbit4", 256'(h3[511]), 256'(1));
    wait_pops(1);
    check("accepted_1", 256'(accepted), 256'(4));

    // Seven-seed layout on the second instance
    for (int k = 0; k < 7; k++) s7[k] = {16{8'(8'h11 * (k + 1))}};
    for (int k = 0; k < 7; k++) begin
      seed7_in = s7[k];
      seed7_valid = 1'b1;
      hs = 1'b0;
      for (int t = 0; t < 100 && !hs; t++) begin
        hs = seed7_ready;
        @(negedge clk);
      end
      if (!hs) check("seed7_timeout", 256'(0), 256'(1));
    end
    seed7_valid = 1'b0;
    @(negedge clk);
    check("hstart7", 256'(hstart7), 256'(1));
    check_msg("msg7", h3_7, build_msg(s7, 7));
    check("len7", 256'(h3_7[63:0]), 256'(64'h380));
    check("padbit7", 256'(h3_7[127]), 256'(1));

    // Random gaps, seed_valid held through HASH/OUT, digest backpressure
    digest_ready = 1'b0;
    acc0 = accepted;
    rand_seeds(s);
    send_msg(s, 3, 1'b1);
    for (int t = 0; t < 300 && !digest_valid; t++) @(negedge clk);
    check("dv_arrived", 256'(digest_valid), 256'(1));
    for (int t = 0; t < 20; t++) begin
      check("dv_hold", 256'(digest_valid), 256'(1));
      if (sb_q.size() > 0) check("digest_hold", digest_out, sb_q[0]);
      @(negedge clk);
    end
    check("accepted_2", 256'(accepted - acc0), 256'(4));
    seed_valid = 1'b0;
    digest_ready = 1'b1;
    @(negedge clk);
    check("ready_after_out", 256'(seed_ready), 256'(1));
    check("dv_cleared", 256'(digest_valid), 256'(0));
    wait_pops(2);

    // Second message right after the handshake
    rand_seeds(s);
    send_msg(s, 2, 1'b0);
    wait_pops(3);

    // Reset pulsed mid-HASH discards the message
    rand_seeds(s);
    send_msg(s, 0, 1'b0);
    if (sb_q.size() > 0) void'(sb_q.pop_back());
    repeat (4) @(negedge clk);
    check("hstart_before_rst", 256'(Hstart), 256'(1));
    #2 reset = 1'b0;
    #1;
    check("mid_rst_hstart", 256'(Hstart), 256'(0));
    check("mid_rst_dv", 256'(digest_valid), 256'(0));
    check_msg("mid_rst_msg", h3, '0);
    check("mid_rst_hstart7", 256'(hstart7), 256'(0));
    check("mid_rst_dv7", 256'(digest7_valid), 256'(0));
    check("mid_rst_digest7", digest7_out, 256'(0));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    rand_seeds(s);
    send_msg(s, 1, 1'b0);
    @(negedge clk);
    check_msg("msg_after_rst", h3, build_msg(s, 4));
    wait_pops(4);
    check("sb_empty", 256'(sb_q.size()), 256'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
